// File: rtl/copr_pkg.sv
// Shared constants and types for the coprocessor interrupt controller.
// Register map, FSM state encoding and ISERV field layout.
package copr_pkg;

  localparam int COPR_IMASK_ADDR = 20;
  localparam int COPR_IMODE_ADDR = 21;
  localparam int COPR_IPEND_ADDR = 22;
  localparam int COPR_ISERV_ADDR = 23;

  localparam int COPR_ISERV_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERV
  } int_state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins combinational priority encoder.
// Channel 0 has the highest priority.
module int_prio_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] id
);

  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = W'(i);
    end
  end

endmodule

// File: rtl/copr_int_ctrl.sv
// Multi-channel interrupt controller with req/ack/eret handshake.
// Define COPR_INT_SYNC_EN to add a 2-flop input synchroniser.
module copr_int_ctrl
  import copr_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int N_INT          = 8,
  parameter int ID_WIDTH       = (N_INT > 1) ? $clog2(N_INT) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_arst_n,
  input  logic [N_INT-1:0]          i_ext_int,
  input  logic                      i_en,
  input  logic [REG_ADDR_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0]     i_din,
  output logic [DATA_WIDTH-1:0]     o_dout,
  input  logic                      i_int_ack,
  input  logic                      i_eret,
  output logic                      o_int_req,
  output logic [ID_WIDTH-1:0]       o_int_id,
  output logic                      o_in_service
);

  logic [N_INT-1:0]    line_s;
  logic [N_INT-1:0]    prev_q;
  logic [N_INT-1:0]    pend_q;
  logic [N_INT-1:0]    pend_d;
  logic [N_INT-1:0]    imask_q;
  logic [N_INT-1:0]    imode_q;
  logic [N_INT-1:0]    rise;
  logic [N_INT-1:0]    w1c;
  logic [N_INT-1:0]    ack_clr;
  logic [N_INT-1:0]    elig;
  logic [ID_WIDTH-1:0] win_id;
  logic [ID_WIDTH-1:0] serv_id_q;
  logic                win_vld;
  logic                ack_take;
  logic                sel_mask;
  logic                sel_mode;
  logic                sel_pend;
  logic                sel_serv;
  int_state_e          state_q;
  int_state_e          state_d;

`ifdef COPR_INT_SYNC_EN
  logic [N_INT-1:0] sync1_q;
  logic [N_INT-1:0] sync2_q;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_ext_int;
      sync2_q <= sync1_q;
    end
  end

  assign line_s = sync2_q;
`else
  assign line_s = i_ext_int;
`endif

  assign sel_mask = i_address == REG_ADDR_WIDTH'(COPR_IMASK_ADDR);
  assign sel_mode = i_address == REG_ADDR_WIDTH'(COPR_IMODE_ADDR);
  assign sel_pend = i_address == REG_ADDR_WIDTH'(COPR_IPEND_ADDR);
  assign sel_serv = i_address == REG_ADDR_WIDTH'(COPR_ISERV_ADDR);

  assign ack_take = (state_q == ST_REQ) && i_int_ack;
  assign rise     = line_s & ~prev_q;
  assign w1c      = (i_en && sel_pend) ? i_din[N_INT-1:0] : '0;
  assign ack_clr  = ack_take ? (N_INT'(1) << o_int_id) : '0;

  // Edge bits latch with set-over-clear; level bits track the line.
  assign pend_d = (imode_q & ((pend_q & ~(w1c | ack_clr)) | rise))
                | (~imode_q & line_s);

  assign elig = pend_q & imask_q;

  int_prio_enc #(
    .N (N_INT),
    .W (ID_WIDTH)
  ) u_prio (
    .req   (elig),
    .valid (win_vld),
    .id    (win_id)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (win_vld) state_d = ST_REQ;
      ST_REQ: begin
        if (i_int_ack)     state_d = ST_SERV;
        else if (!win_vld) state_d = ST_IDLE;
      end
      ST_SERV: if (i_eret) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q      <= ST_IDLE;
      prev_q       <= '0;
      pend_q       <= '0;
      imask_q      <= '0;
      imode_q      <= '0;
      serv_id_q    <= '0;
      o_int_id     <= '0;
      o_int_req    <= 1'b0;
      o_in_service <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= line_s;
      pend_q       <= pend_d;
      o_int_req    <= state_d == ST_REQ;
      o_in_service <= state_d == ST_SERV;
      if (i_en && sel_mask) imask_q <= i_din[N_INT-1:0];
      if (i_en && sel_mode) imode_q <= i_din[N_INT-1:0];
      if (state_d == ST_REQ) o_int_id <= win_id;
      if (ack_take) serv_id_q <= o_int_id;
    end
  end

  always_comb begin
    o_dout = '0;
    unique case (1'b1)
      sel_mask: o_dout[N_INT-1:0] = imask_q;
      sel_mode: o_dout[N_INT-1:0] = imode_q;
      sel_pend: o_dout[N_INT-1:0] = pend_q;
      sel_serv: begin
        o_dout[COPR_ISERV_BIT] = o_in_service;
        o_dout[ID_WIDTH-1:0]   = serv_id_q;
      end
      default: o_dout = '0;
    endcase
  end

endmodule

// File: tb/tb_copr_int_ctrl.sv
// Directed self-checking bench for copr_int_ctrl.
// Targets the default build (no input synchroniser).
module tb_copr_int_ctrl;
  import copr_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  ext = '0;
  logic          en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          ack = 1'b0;
  logic          eret = 1'b0;
  logic          req;
  logic [IW-1:0] id;
  logic          insvc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  copr_int_ctrl #(
    .DATA_WIDTH     (DW),
    .REG_ADDR_WIDTH (AW),
    .N_INT          (N),
    .ID_WIDTH       (IW)
  ) dut (
    .i_clk        (clk),
    .i_arst_n     (rst_n),
    .i_ext_int    (ext),
    .i_en         (en),
    .i_address    (addr),
    .i_din        (din),
    .o_dout       (dout),
    .i_int_ack    (ack),
    .i_eret       (eret),
    .o_int_req    (req),
    .o_int_id     (id),
    .o_in_service (insvc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    addr = AW'(a);
    din  = d;
    en   = 1'b1;
    step();
    en   = 1'b0;
  endtask

  task automatic rd(input string tag, input int a, input logic [31:0] exp);
    addr = AW'(a);
    #1;
    chk(tag, dout, exp);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1;
    step();
    eret = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_id", 32'(id), 32'd0);
    chk("rst_insvc", 32'(insvc), 32'd0);
    rd("rst_imask", COPR_IMASK_ADDR, 32'h0);
    rd("rst_imode", COPR_IMODE_ADDR, 32'h0);
    rd("rst_ipend", COPR_IPEND_ADDR, 32'h0);
    rd("rst_iserv", COPR_ISERV_ADDR, 32'h0);
    rd("unmapped", 3, 32'h0);
    rst_n = 1'b1;
    step();

    // single edge pulse on line 0
    wr(COPR_IMASK_ADDR, 32'h01);
    wr(COPR_IMODE_ADDR, 32'h01);
    rd("t1_imask", COPR_IMASK_ADDR, 32'h01);
    ext = 8'h01;
    step();
    ext = 8'h00;
    chk("t1_req_early", 32'(req), 32'd0);
    rd("t1_pend_set", COPR_IPEND_ADDR, 32'h01);
    step();
    chk("t1_req", 32'(req), 32'd1);
    chk("t1_id", 32'(id), 32'd0);
    pulse_ack();
    chk("t1_req_ack", 32'(req), 32'd0);
    chk("t1_insvc", 32'(insvc), 32'd1);
    rd("t1_pend_clr", COPR_IPEND_ADDR, 32'h0);
    rd("t1_iserv", COPR_ISERV_ADDR, 32'h8000_0000);
    pulse_eret();
    chk("t1_eret_insvc", 32'(insvc), 32'd0);
    step();
    chk("t1_idle_req", 32'(req), 32'd0);

    // simultaneous edges on 5 and 2
    wr(COPR_IMASK_ADDR, 32'hFF);
    wr(COPR_IMODE_ADDR, 32'h3F);
    ext = 8'h24;
    step();
    ext = 8'h00;
    step();
    chk("t2_req", 32'(req), 32'd1);
    chk("t2_id2", 32'(id), 32'd2);
    pulse_ack();
    rd("t2_pend5", COPR_IPEND_ADDR, 32'h20);
    rd("t2_iserv", COPR_ISERV_ADDR, 32'h8000_0002);
    pulse_eret();
    chk("t2_eret_req", 32'(req), 32'd0);
    step();
    chk("t2_req5", 32'(req), 32'd1);
    chk("t2_id5", 32'(id), 32'd5);
    pulse_ack();
    pulse_eret();
    step();
    chk("t2_done", 32'(req), 32'd0);

    // level 6 preempted by edge 1 before ack
    ext = 8'h40;
    step();
    step();
    chk("t3_id6", 32'(id), 32'd6);
    ext = 8'h42;
    step();
    step();
    chk("t3_id1", 32'(id), 32'd1);
    chk("t3_req", 32'(req), 32'd1);
    pulse_ack();
    rd("t3_iserv", COPR_ISERV_ADDR, 32'h8000_0001);
    ext = 8'h00;
    pulse_eret();
    step();
    rd("t3_pend", COPR_IPEND_ADDR, 32'h0);
    chk("t3_idle", 32'(req), 32'd0);

    // level line 3 drops before ack
    wr(COPR_IMODE_ADDR, 32'h37);
    ext = 8'h08;
    step();
    step();
    chk("t4_req", 32'(req), 32'd1);
    chk("t4_id3", 32'(id), 32'd3);
    ext = 8'h00;
    step();
    step();
    chk("t4_drop_req", 32'(req), 32'd0);
    rd("t4_pend3", COPR_IPEND_ADDR, 32'h0);
    ext = 8'h08;
    step();
    wr(COPR_IPEND_ADDR, 32'h08);
    rd("t4_w1c_level", COPR_IPEND_ADDR, 32'h08);
    ext = 8'h00;
    step();
    step();
    chk("t4_idle", 32'(req), 32'd0);

    // W1C racing a new edge on channel 4 (masked)
    wr(COPR_IMASK_ADDR, 32'hEF);
    ext = 8'h10;
    step();
    ext = 8'h00;
    step();
    rd("t5_pend4", COPR_IPEND_ADDR, 32'h10);
    ext = 8'h10;
    wr(COPR_IPEND_ADDR, 32'h10);
    rd("t5_set_wins", COPR_IPEND_ADDR, 32'h10);
    wr(COPR_IPEND_ADDR, 32'h10);
    rd("t5_w1c", COPR_IPEND_ADDR, 32'h0);
    chk("t5_no_req", 32'(req), 32'd0);
    ext = 8'h00;
    step();

    // reset while in service
    wr(COPR_IMASK_ADDR, 32'hFF);
    ext = 8'h01;
    step();
    ext = 8'h00;
    step();
    chk("t6_req", 32'(req), 32'd1);
    ack = 1'b1;
    step();
    chk("t6_insvc", 32'(insvc), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    ack = 1'b0;
    chk("t6_rst_insvc", 32'(insvc), 32'd0);
    chk("t6_rst_req", 32'(req), 32'd0);
    rd("t6_rst_imask", COPR_IMASK_ADDR, 32'h0);
    rd("t6_rst_iserv", COPR_ISERV_ADDR, 32'h0);
    step();
    rst_n = 1'b1;
    ext = 8'h01;
    step();
    step();
    step();
    chk("t6_masked", 32'(req), 32'd0);
    wr(COPR_IMASK_ADDR, 32'h01);
    step();
    chk("t6_reenable_req", 32'(req), 32'd1);
    chk("t6_reenable_id", 32'(id), 32'd0);
    ext = 8'h00;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/copr_int_ctrl.md
# copr_int_ctrl

Parametrised multi-channel interrupt controller for the coprocessor, replacing the single `i_ext_int` line into the MIPS core with `N_INT` external sources. Each source has per-channel:
- mask;
- edge or level mode;
- pending latch.

The block arbitrates by fixed priority and hands one request at a time to the coprocessor over a req/ack handshake. It blocks further requests until `eret` retires from the memory-access stage. Software reaches its registers through the coprocessor move path: same address, enable and data buses as the coprocessor register file.

## Interface
Parameters:
- `DATA_WIDTH`, 32, coprocessor data bus width.
- `REG_ADDR_WIDTH`, 5, coprocessor register address width.
- `N_INT`, 8, number of external interrupt lines; legal range 1..`DATA_WIDTH`.
- `ID_WIDTH`, `N_INT`>1 ? $clog2(`N_INT`) : 1, width of the channel index.

Ports:
- `i_clk`  in  1  core clock.
- `i_arst_n`  in  1  asynchronous active-low reset.
- `i_ext_int`  in  `N_INT`  external interrupt lines.
- `i_en`  in  1  coprocessor register write enable (mtc0).
- `i_address`  in  `REG_ADDR_WIDTH`  coprocessor register address, used for both read and write.
- `i_din`  in  `DATA_WIDTH`  write data.
- `o_dout`  out  `DATA_WIDTH`  combinational read data; 0 for unmapped addresses.
- `i_int_ack`  in  1  coprocessor has taken the interrupt: stages killed, epc saved.
- `i_eret`  in  1  eret retired in the memory-access stage.
- `o_int_req`  out  1  registered interrupt request.
- `o_int_id`  out  `ID_WIDTH`  registered index of the requesting channel.
- `o_in_service`  out  1  an interrupt has been acknowledged and not yet returned.

## Operation
- Registers (addresses are package constants):
  - IMASK: read/write; 1 = enabled.
  - IMODE: read/write; 1 = edge, 0 = level.
  - IPEND: read; write-1-to-clear, acting on edge channels only.
  - ISERV: read only; bit 31 = in service, low `ID_WIDTH` bits = id in service.
- All registers are `N_INT` bits, zero-extended on read. Writes take effect at the clock edge where `i_en`=1.
- Edge channel: the rising edge of the sampled line versus the previous sample sets the IPEND bit. The bit is cleared by W1C, or by `i_int_ack` when that channel is `o_int_id`. If a set and a clear hit the same cycle, the set wins.
- Level channel: the IPEND bit equals the sampled line and is never latched. W1C has no effect.
- Eligible = IPEND & IMASK. The winner is the lowest eligible index (channel 0 highest priority).
- FSM states IDLE, REQ, SERV:
  - IDLE -> REQ when any channel is eligible.
  - REQ -> SERV on `i_int_ack`; the current `o_int_id` is captured into ISERV.
  - REQ -> IDLE when no channel is eligible (level line dropped, masked, or W1C) and `i_int_ack`=0. Ack wins over drop.
  - SERV -> IDLE on `i_eret`.
  - `i_eret` is ignored in IDLE and REQ. `i_int_ack` is ignored outside REQ.
- `o_int_req`=1 exactly in REQ.
- In REQ, `o_int_id` is re-registered every cycle to the current winner, so a higher-priority arrival preempts before ack.
- No nesting: eligibility is still tracked in SERV, but no request is raised.

## Timing
- Reset values:
  - `o_int_req`=0, `o_int_id`=0, `o_in_service`=0.
  - IMASK=0, IMODE=0, IPEND=0, ISERV=0.
  - Previous-sample flops = 0; state IDLE.
- Line sampled high at edge k with the previous sample low: IPEND set at edge k; `o_int_req` high after edge k+1. Latency is 2 clocks from sampled input to request, without synchroniser.
- `i_int_ack` at edge k: `o_int_req` low and `o_in_service` high after edge k; the acked edge pending bit clears at edge k.
- `i_eret` at edge k: `o_in_service` low after k. If a channel is still eligible, `o_int_req` rises after k+1.
- Reset asserted mid-handshake: everything returns to reset values immediately, including a pending ack and the in-service state.

## Configuration
- `COPR_INT_SYNC_EN` defined: each `i_ext_int` bit passes a 2-flop synchroniser (reset 0) before edge and level detection; input-to-request latency becomes 4 clocks.
- `COPR_INT_SYNC_EN` undefined: lines are sampled directly; the lines must be synchronous to `i_clk`.

## Structure
- Shared package `copr_pkg`:
  - register address constants `COPR_IMASK_ADDR`, `COPR_IMODE_ADDR`, `COPR_IPEND_ADDR`, `COPR_ISERV_ADDR`;
  - FSM state typedef;
  - ISERV in-service bit position constant.
- One sub-module, `int_prio_enc`: parametrised combinational lowest-index priority encoder, outputs `valid` and `id`.

## Test plan
- Reset, then IMASK=0x01, IMODE=0x01, pulse line 0 for one cycle -> `o_int_req`=1, `o_int_id`=0 two clocks later; ack -> IPEND=0, ISERV=0x8000_0000.
- IMASK=0xFF, raise edge lines 5 and 2 on the same cycle -> `o_int_id`=2; ack, eret -> new request with `o_int_id`=5.
- In REQ for line 6 (level), raise line 1 before ack -> `o_int_id` switches to 1 the next cycle; ack captures ISERV id 1.
- Level line 3 rises then drops before ack -> REQ returns to IDLE, `o_int_req`=0, IPEND bit 3=0; W1C 0x08 on a level channel leaves IPEND unchanged.
- Edge pending on channel 4, W1C 0x10 in the same cycle as a new edge on channel 4 -> IPEND bit 4 stays 1.
- Assert `i_arst_n`=0 while in SERV -> `o_in_service`=0, IMASK=0, and no request after release until software re-enables.
